// File: rtl/wallace_mac_pkg.sv
// Shared types for the Wallace multiplier accumulator: product/accumulator widths
// and the beat tag that travels alongside the multiplier pipeline.
package wallace_mac_pkg;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 40;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [ACC_W-1:0]  acc_t;

    typedef struct packed {
        logic vld;
        logic last;
    } mac_tag_t;

endpackage

// File: rtl/wallace_mac_accumulator_tag_delay.sv
// mac_tag_delay: LATENCY-stage shift register of beat tags. It mirrors the multiplier
// pipeline so that each product can be matched to the beat that produced it.
module mac_tag_delay
    import wallace_mac_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  mac_tag_t i_tag,
    output mac_tag_t o_tag
);

    mac_tag_t r_stage [LATENCY];

    // NOTE: unlike a data memory, every stage is reset here, because a stale vld
    // surviving reset would fold a discarded product into the next group.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[LATENCY-1];

endmodule

// File: rtl/wallace_mac_accumulator.sv
// Group accumulator behind the pipelined Wallace multiplier; owns issue flow control.
// Build option MAC_SAT_EN: clamp the group sum on overflow instead of wrapping.
module wallace_mac_accumulator
    import wallace_mac_pkg::mac_tag_t;
#(
    parameter int LATENCY = 4,
    parameter int PROD_W  = wallace_mac_pkg::PROD_W,
    parameter int ACC_W   = wallace_mac_pkg::ACC_W,   // must be >= PROD_W
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_last,
    output logic              issue_ready,
    input  logic [PROD_W-1:0] P,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;
    logic             r_last_inflight;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_sat;

    mac_tag_t         w_tag_in;
    mac_tag_t         w_tag_out;
    logic             w_accept;
    logic             w_do_accum;
    logic             w_do_close;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_next_acc;
    logic [CNT_W-1:0] w_cnt_inc;

    // A last beat is held off until its result is guaranteed a free output register.
    assign issue_ready = !issue_last || (!r_last_inflight && (!r_out_valid || out_ready));
    assign w_accept    = issue_valid && issue_ready;

    assign w_tag_in.vld  = w_accept;
    assign w_tag_in.last = w_accept && issue_last;

    mac_tag_delay #(
        .LATENCY (LATENCY)
    ) u_tag_delay (
        .clock (clock),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_do_accum = w_tag_out.vld && !w_tag_out.last;
    assign w_do_close = w_tag_out.vld &&  w_tag_out.last;

    assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, P};
    assign w_carry   = w_sum[ACC_W];
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    assign w_next_acc = (r_sticky || w_carry) ? ACC_MAX : w_sum[ACC_W-1:0];
`else
    assign w_next_acc = w_sum[ACC_W-1:0];
`endif

    // NOTE: all state below uses <= so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_do_close) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_do_accum) begin
            r_acc    <= w_next_acc;
            r_cnt    <= w_cnt_inc;
            r_sticky <= r_sticky || w_carry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_inflight <= 1'b0;
        end else if (w_accept && issue_last) begin
            r_last_inflight <= 1'b1;
        end else if (w_do_close) begin
            r_last_inflight <= 1'b0;
        end
    end

    // A close takes priority over a pop so a new result never loses a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_do_close) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_next_acc;
            r_out_count <= w_cnt_inc;
            r_out_sat   <= r_sticky || w_carry;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// Directed bench for wallace_mac_accumulator with a behavioural 4-stage multiplier
// in front of it. Build option MAC_SAT_EN selects the clamping expectations.
module tb_wallace_mac_accumulator;

    localparam int LATENCY = 4;
    localparam int PROD_W  = 32;
    localparam int ACC_W   = 40;
    localparam int CNT_W   = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic              issue_last;
    logic              issue_ready;
    logic [PROD_W-1:0] P;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    logic [15:0]       a_in;
    logic [15:0]       b_in;
    logic [PROD_W-1:0] mul_pipe [LATENCY];
    int                cyc = 0;
    int                last_edge;
    int                n_total = 0;
    int                n_pass = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in for the Wallace multiplier: product visible LATENCY edges after issue.
    always @(posedge clock) begin
        mul_pipe[0] <= a_in * b_in;
        for (int i = 1; i < LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign P = mul_pipe[LATENCY-1];

    wallace_mac_accumulator #(
        .LATENCY (LATENCY),
        .PROD_W  (PROD_W),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_last  (issue_last),
        .issue_ready (issue_ready),
        .P           (P),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_sat     (out_sat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one beat at a negedge, hold until accepted (bounded), return at the
    // following negedge with last_edge set to the acceptance edge.
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last,
                        output int waited);
        a_in        = a;
        b_in        = b;
        issue_last  = last;
        issue_valid = 1'b1;
        waited      = 0;
        #1;
        while (!issue_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        @(posedge clock);
        @(negedge clock);
        last_edge   = cyc;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int stalls;
        int m;
        logic seen;
        logic [63:0] full;
        logic [63:0] exp_big;

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        out_ready   = 1'b0;
        a_in        = '0;
        b_in        = '0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_sat",   64'(out_sat),   64'd0);
        issue_last = 1'b1;
        #1;
        check("rst_issue_ready_last", 64'(issue_ready), 64'd1);
        issue_last = 1'b0;
        reset      = 1'b0;
        @(negedge clock);

        // Three-beat group: 6 + 256 + 1
        out_ready = 1'b1;
        stalls = 0;
        beat(16'd2,    16'd3,    1'b0, st); stalls += st;
        beat(16'h0010, 16'h0010, 1'b0, st); stalls += st;
        beat(16'd1,    16'd1,    1'b1, st); stalls += st;
        m = last_edge;
        check("g3_stalls", 64'(stalls), 64'd0);
        wait_valid("g3");
        check("g3_latency", 64'(cyc),       64'(m + LATENCY));
        check("g3_data",    64'(out_data),  64'h107);
        check("g3_count",   64'(out_count), 64'd3);
        check("g3_sat",     64'(out_sat),   64'd0);
        @(negedge clock);
        check("g3_single_pulse", 64'(out_valid), 64'd0);

        // Back-to-back single-beat groups with the consumer stalled
        out_ready = 1'b0;
        beat(16'hFFFF, 16'hFFFF, 1'b1, st);
        check("b2b_first_stall", 64'(st), 64'd0);
        a_in        = 16'h1234;
        b_in        = 16'h5678;
        issue_last  = 1'b1;
        issue_valid = 1'b1;
        #1;
        check("b2b_ready_inflight", 64'(issue_ready), 64'd0);
        wait_valid("b2b_first");
        check("b2b_first_data",  64'(out_data),  64'hFFFE0001);
        check("b2b_first_count", 64'(out_count), 64'd1);
        check("b2b_first_sat",   64'(out_sat),   64'd0);
        #1;
        check("b2b_ready_full", 64'(issue_ready), 64'd0);
        @(negedge clock);
        check("b2b_first_held", 64'(out_data), 64'hFFFE0001);
        out_ready = 1'b1;
        #1;
        check("b2b_ready_on_pop", 64'(issue_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        m           = cyc;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        out_ready   = 1'b0;
        check("b2b_popped", 64'(out_valid), 64'd0);
        wait_valid("b2b_second");
        check("b2b_second_latency", 64'(cyc),       64'(m + LATENCY));
        check("b2b_second_data",    64'(out_data),  64'h06260060);
        check("b2b_second_count",   64'(out_count), 64'd1);
        out_ready = 1'b1;
        @(negedge clock);
        check("b2b_second_popped", 64'(out_valid), 64'd0);

        // 300 max-product beats plus a max-product last beat overflow 40 bits
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            beat(16'hFFFF, 16'hFFFF, 1'b0, st);
            stalls += st;
        end
        beat(16'hFFFF, 16'hFFFF, 1'b1, st);
        stalls += st;
        check("big_stalls", 64'(stalls), 64'd0);
        full = 64'd301 * 64'hFFFE0001;
`ifdef MAC_SAT_EN
        exp_big = 64'hFF_FFFF_FFFF;
`else
        exp_big = {24'd0, full[39:0]};
`endif
        wait_valid("big");
        check("big_data",  64'(out_data),  exp_big);
        check("big_count", 64'(out_count), 64'd301);
        check("big_sat",   64'(out_sat),   64'd1);
        @(negedge clock);

        // Reset with a partial group accumulated and beats still in flight
        beat(16'd5, 16'd5, 1'b0, st);
        beat(16'd5, 16'd5, 1'b0, st);
        beat(16'd5, 16'd5, 1'b0, st);
        beat(16'd5, 16'd5, 1'b0, st);
        beat(16'd7, 16'd7, 1'b0, st);
        beat(16'd7, 16'd7, 1'b1, st);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            seen = seen | out_valid;
        end
        check("rst_flush_no_valid", 64'(seen), 64'd0);
        issue_last = 1'b1;
        #1;
        check("rst_flush_ready_last", 64'(issue_ready), 64'd1);
        issue_last = 1'b0;
        beat(16'd2, 16'd3, 1'b1, st);
        wait_valid("post_rst");
        check("post_rst_data",  64'(out_data),  64'd6);
        check("post_rst_count", 64'(out_count), 64'd1);
        check("post_rst_sat",   64'(out_sat),   64'd0);
        @(negedge clock);

        // Held result, next group's last beat accepted on the popping edge. Under
        // this issue_ready rule the pop always lands on the acceptance edge.
        out_ready = 1'b0;
        beat(16'd3, 16'd3, 1'b1, st);
        wait_valid("hold_a");
        check("hold_a_data", 64'(out_data), 64'd9);
        beat(16'd4, 16'd4, 1'b0, st);
        check("hold_nonlast_stall", 64'(st), 64'd0);
        check("hold_a_stable_valid", 64'(out_valid), 64'd1);
        check("hold_a_stable_data",  64'(out_data),  64'd9);
        a_in        = 16'd5;
        b_in        = 16'd5;
        issue_last  = 1'b1;
        issue_valid = 1'b1;
        #1;
        check("hold_ready_blocked", 64'(issue_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("hold_ready_on_pop", 64'(issue_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        m           = cyc;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        out_ready   = 1'b0;
        check("hold_a_popped", 64'(out_valid), 64'd0);
        wait_valid("hold_b");
        check("hold_b_latency", 64'(cyc),       64'(m + LATENCY));
        check("hold_b_data",    64'(out_data),  64'd41);
        check("hold_b_count",   64'(out_count), 64'd2);
        out_ready = 1'b1;
        @(negedge clock);

        // 64 continuous non-last beats then a last beat
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            beat(16'd1, 16'd1, 1'b0, st);
            stalls += st;
        end
        check("stream_no_stall", 64'(stalls), 64'd0);
        beat(16'd1, 16'd1, 1'b1, st);
        wait_valid("stream");
        check("stream_data",  64'(out_data),  64'd65);
        check("stream_count", 64'(out_count), 64'd65);
        check("stream_sat",   64'(out_sat),   64'd0);
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
